dequant_seq: RTL and testbench

DEQUANT_SEQ -- requirements
Module: dequant_seq

---
 rtl/dequant_seq.sv | 88 ++++++++
 tb/tb_dequant_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dequant_seq.sv
// Two-stage dequantiser: scales each incoming coefficient by a byte from an external,
// registered quantisation-table ROM. Define ZIGZAG_EN for zigzag-ordered input.
module dequant_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        din_valid,
  input  logic [11:0] din,
  output logic        din_ready,
  output logic [5:0]  rom_a,
  input  logic [7:0]  rom_d,
  output logic        dout_valid,
  output logic [11:0] dout,
  output logic        dout_last,
  input  logic        dout_ready
);

`ifdef ZIGZAG_EN
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] addr_map(input logic [5:0] i);
    return ZZ[i];
  endfunction
`else
  function automatic logic [5:0] addr_map(input logic [5:0] i);
    return i;
  endfunction
`endif

  logic [5:0]         idx;
  logic               s1_valid;
  logic signed [11:0] s1_din;
  logic [5:0]         s1_idx;
  logic               s1_last;
  logic               s1_advance;
  logic               in_xfer;
  logic signed [20:0] prod;
  logic [11:0]        dout_next;
  logic               rnd_unused_hi;
  logic [7:0]         rnd_unused_lo;

  always_comb begin
    s1_advance = !dout_valid || dout_ready;
    din_ready  = !s1_valid || s1_advance;
    in_xfer    = din_valid && din_ready;
    // Hold the ROM on the S1 entry while stalled so rom_d keeps matching it.
    rom_a      = (s1_valid && !s1_advance) ? addr_map(s1_idx) : addr_map(idx);
    prod       = s1_din * $signed({1'b0, rom_d});
    {rnd_unused_hi, dout_next, rnd_unused_lo} = prod + 21'sd128;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx      <= '0;
      s1_valid <= 1'b0;
      s1_din   <= '0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_din   <= din;
      s1_idx   <= idx;
      s1_last  <= (idx == 6'd63);
      idx      <= idx + 6'd1;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_last  <= 1'b0;
    end else if (s1_advance) begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout      <= dout_next;
        dout_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_dequant_seq.sv
// Directed bench for dequant_seq with a registered ROM model and an output monitor.
module tb_dequant_seq;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        din_valid = 1'b0;
  logic [11:0] din = '0;
  logic        din_ready;
  logic [5:0]  rom_a;
  logic [7:0]  rom_d;
  logic        dout_valid;
  logic [11:0] dout;
  logic        dout_last;
  logic        dout_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rom [64];
  logic [5:0] idx_m = '0;

  typedef struct {
    logic [11:0] d;
    logic        last;
    int          cyc;
  } out_t;

  out_t        got_q[$];
  logic [11:0] exp_d_q[$];
  logic        exp_l_q[$];

  dequant_seq dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .rom_a(rom_a), .rom_d(rom_d), .dout_valid(dout_valid), .dout(dout),
    .dout_last(dout_last), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_d <= rom[rom_a];
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    out_t o;
    if (rstn && dout_valid && dout_ready) begin
      o.d = dout;
      o.last = dout_last;
      o.cyc = cyc;
      got_q.push_back(o);
    end
  end

`ifdef ZIGZAG_EN
  localparam int TB_ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  function automatic logic [5:0] map_idx(input logic [5:0] i);
    return 6'(TB_ZZ[i]);
  endfunction
  localparam logic [11:0] EXP_IDX2 = 12'd128;
`else
  function automatic logic [5:0] map_idx(input logic [5:0] i);
    return i;
  endfunction
  localparam logic [11:0] EXP_IDX2 = 12'd108;
`endif

  function automatic logic [11:0] model(input logic [11:0] d, input logic [5:0] i);
    int p;
    p = $signed(d) * int'(rom[map_idx(i)]) + 128;
    return 12'(p >>> 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call away from a clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    idx_m = '0;
    @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_last", 32'(dout_last), 0);
    chk("rst_rom_a", 32'(rom_a), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rel_din_ready", 32'(din_ready), 1);
    chk("rel_dout_valid", 32'(dout_valid), 0);
  endtask

  task automatic xfer_check(input string tag, input logic [11:0] d, input logic [11:0] exp,
                            input logic exp_last);
    @(posedge clk);
    #1 din_valid = 1'b1;
    din = d;
    @(posedge clk);
    #1 din_valid = 1'b0;
    idx_m++;
    @(negedge clk);
    chk({tag, "_lat"}, 32'(dout_valid), 0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(dout_valid), 1);
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_last"}, 32'(dout_last), 32'(exp_last));
  endtask

  task automatic stream(input int n, input int stall_idx, input bit drain, input string tag);
    int k = 0;
    int budget = 0;
    int stall_left = 0;
    bit stalled = 0;
    logic acc;
    logic [11:0] held = '0;
    logic [11:0] cur;
    got_q.delete();
    exp_d_q.delete();
    exp_l_q.delete();
    @(posedge clk);
    #1;
    cur = 12'($urandom_range(0, 4095));
    din = cur;
    din_valid = 1'b1;
    while (k < n && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (stall_left > 0) begin
        chk({tag, "_stall_rom_a"}, 32'(rom_a), 32'(map_idx(6'(stall_idx))));
        chk({tag, "_stall_dout"}, 32'(dout), 32'(held));
        chk({tag, "_stall_valid"}, 32'(dout_valid), 1);
        chk({tag, "_stall_din_ready"}, 32'(din_ready), 0);
      end
      acc = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) dout_ready = 1'b1;
      end
      if (acc) begin
        exp_d_q.push_back(model(cur, idx_m));
        exp_l_q.push_back(idx_m == 6'd63);
        if (!stalled && stall_idx >= 0 && idx_m == 6'(stall_idx)) begin
          stalled = 1;
          dout_ready = 1'b0;
          stall_left = 3;
          held = dout;
        end
        idx_m++;
        k++;
        if (k < n) begin
          cur = 12'($urandom_range(0, 4095));
          din = cur;
        end else begin
          din_valid = 1'b0;
        end
      end
    end
    din_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(k), 32'(n));
    if (drain) begin
      budget = 0;
      while (got_q.size() < exp_d_q.size() && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_d_q.size()));
      for (int i = 0; i < exp_d_q.size() && i < got_q.size(); i++) begin
        chk($sformatf("%s_dout[%0d]", tag, i), 32'(got_q[i].d), 32'(exp_d_q[i]));
        chk($sformatf("%s_last[%0d]", tag, i), 32'(got_q[i].last), 32'(exp_l_q[i]));
        if (stall_idx < 0 && i > 0)
          chk($sformatf("%s_gap[%0d]", tag, i), 32'(got_q[i].cyc - got_q[i-1].cyc), 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'(i * 37 + 11);
    rom[0]  = 8'hFF;
    rom[1]  = 8'h80;
    rom[2]  = 8'h6C;
    rom[8]  = 8'h80;
    rom[63] = 8'h19;

    #1;
    do_reset();

    xfer_check("idx0_100", 12'd100, 12'd100, 1'b0);
    xfer_check("idx1_100", 12'd100, 12'd50, 1'b0);
    xfer_check("idx2_256", 12'd256, EXP_IDX2, 1'b0);
    for (int i = 3; i < 63; i++)
      xfer_check($sformatf("fill%0d", i), 12'd0, 12'd0, 1'b0);
    xfer_check("idx63_min", 12'h800, 12'hF38, 1'b1);
    xfer_check("wrap_idx0_max", 12'h7FF, 12'h7F7, 1'b0);

    @(negedge clk);
    do_reset();
    stream(64, 5, 1'b1, "stall");
    stream(128, -1, 1'b1, "b2b");

    stream(20, -1, 1'b0, "partial");
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(dout_valid), 0);
    end
    stream(64, -1, 1'b1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
